// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump walker state encoding.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file's second read port over every architectural register
// and streams (index, value) beats out on a valid/ready interface for debug dumps.
// Read-only towards the register file.
//
// state | meaning
// IDLE  | waiting for start; read address holds its last value
// READ  | read address = current index; value captured on the closing edge
// SEND  | captured beat presented; held until the consumer accepts it
// DONE  | one-cycle completion pulse after the last beat was accepted
//
// Note: i_rst_n is active-high and asynchronous despite its name.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REG_COUNT,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = XLEN,
  parameter bit SKIP_X0  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rf_addr,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done
);

  // x0 is hard-wired zero, so a skipping walk starts at index 1.
  localparam logic [ADDR_W-1:0] IDX_FIRST = SKIP_X0 ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);

  dump_state_e       r_state;
  dump_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_capture;
  logic              w_handshake;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  assign w_handshake = (r_state == SEND) && i_out_ready;

  // The index only moves when entering READ, so it doubles as the read address
  // and naturally holds its last value while idle.
  assign o_rf_addr   = r_idx;
  assign o_out_valid = (r_state == SEND);
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state == READ) || (r_state == SEND);
  assign o_done      = (r_state == DONE);

  // Next-state and index update; abort overrides start and any handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    if (i_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_state_nxt = READ;
            w_idx_nxt   = IDX_FIRST;
          end
        end
        READ: begin
          w_capture   = 1'b1;
          w_state_nxt = SEND;
        end
        SEND: begin
          if (w_handshake) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt = DONE;
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_state_nxt = READ;
            end
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and walk index registers.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Capture register: the register file writes on the same edge, so a
  // concurrent write to the register being read is seen as its old value.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      r_out_addr <= '0;
      r_out_data <= '0;
    end else if (w_capture) begin
      r_out_addr <= r_idx;
      r_out_data <= i_rf_data;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file and
// per-instance scoreboards of expected (index, value) beats.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;

  logic [31:0] rf [32];
  logic        preload = 1'b0;
  logic        wr_en   = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  // Register file model: writes land on the clock edge, reads are combinational.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h0101_0101;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  logic [4:0]  a_rf_addr, a_out_addr, b_rf_addr, b_out_addr;
  logic [31:0] a_rf_data, a_out_data, b_rf_data, b_out_data;
  logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;

  assign a_rf_data = rf[a_rf_addr];
  assign b_rf_data = rf[b_rf_addr];

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst), .i_start(start_a), .i_abort(abort_a),
    .o_rf_addr(a_rf_addr), .i_rf_data(a_rf_data),
    .o_out_valid(a_valid), .i_out_ready(ready_a),
    .o_out_addr(a_out_addr), .o_out_data(a_out_data),
    .o_busy(a_busy), .o_done(a_done)
  );

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst), .i_start(start_b), .i_abort(abort_b),
    .o_rf_addr(b_rf_addr), .i_rf_data(b_rf_data),
    .o_out_valid(b_valid), .i_out_ready(ready_b),
    .o_out_addr(b_out_addr), .o_out_data(b_out_data),
    .o_busy(b_busy), .o_done(b_done)
  );

  beat_t q_a[$];
  beat_t q_b[$];

  int n_pass = 0, n_total = 0, n_fail = 0;
  int cyc;
  int beats_a, first_cyc_a, last_cyc_a, done_cnt_a, done_cyc_a;
  int beats_b, first_cyc_b, done_cnt_b, done_cyc_b, first_addr_b, last_addr_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input int i, input logic [31:0] x9v);
    return (i == 9) ? x9v : 32'(i) * 32'h0101_0101;
  endfunction

  task automatic push_a(input int first, input int last, input logic [31:0] x9v);
    for (int i = first; i <= last; i++) begin
      beat_t e;
      e.addr = 5'(i);
      e.data = reg_val(i, x9v);
      q_a.push_back(e);
    end
  endtask

  task automatic push_b(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      beat_t e;
      e.addr = 5'(i);
      e.data = reg_val(i, 32'h0909_0909);
      q_b.push_back(e);
    end
  endtask

  // Observes the current cycle: a beat transfers when valid and ready are both high.
  task automatic mon();
    beat_t e;
    if (a_valid && ready_a) begin
      check("a_beat_expected", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_out_addr", a_out_addr, e.addr);
        check("a_out_data", a_out_data, e.data);
      end
      if (beats_a == 0) first_cyc_a = cyc;
      last_cyc_a = cyc;
      beats_a++;
    end
    if (a_done) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (b_valid && ready_b) begin
      check("b_beat_expected", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_out_addr", b_out_addr, e.addr);
        check("b_out_data", b_out_data, e.data);
      end
      if (beats_b == 0) begin
        first_cyc_b  = cyc;
        first_addr_b = int'(b_out_addr);
      end
      last_addr_b = int'(b_out_addr);
      beats_b++;
    end
    if (b_done) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  endtask

  task automatic step();
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clr_mon();
    cyc = 0;
    beats_a = 0; first_cyc_a = -1; last_cyc_a = -1; done_cnt_a = 0; done_cyc_a = -1;
    beats_b = 0; first_cyc_b = -1; done_cnt_b = 0; done_cyc_b = -1;
    first_addr_b = -1; last_addr_b = -1;
  endtask

  task automatic run_a(input int bound);
    for (int k = 0; k < bound && done_cnt_a == 0; k++) step();
    repeat (3) step();
  endtask

  task automatic run_b(input int bound);
    for (int k = 0; k < bound && done_cnt_b == 0; k++) step();
    repeat (3) step();
  endtask

  task automatic kick_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  initial begin
    clr_mon();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", a_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_out_addr", a_out_addr, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_rf_addr", a_rf_addr, 0);
    check("rst_b_valid", b_valid, 0);
    rst = 1'b0;
    step();
    preload = 1'b1;
    step();
    preload = 1'b0;

    // Full dump with the consumer always ready.
    clr_mon();
    push_a(0, 31, 32'h0909_0909);
    kick_a();
    check("full_c1_busy", a_busy, 1);
    check("full_c1_valid", a_valid, 0);
    check("full_c1_rf_addr", a_rf_addr, 0);
    run_a(150);
    check("full_beats", beats_a, 32);
    check("full_first_valid_cyc", first_cyc_a, 2);
    check("full_last_valid_cyc", last_cyc_a, 64);
    check("full_done_count", done_cnt_a, 1);
    check("full_done_cyc", done_cyc_a, 65);
    check("full_sb_empty", q_a.size(), 0);
    check("full_idle_busy", a_busy, 0);

    // Backpressure at index 7.
    clr_mon();
    push_a(0, 31, 32'h0909_0909);
    kick_a();
    for (int k = 0; k < 100 && !(a_valid && a_out_addr == 5'd7); k++) step();
    check("bp_reach7", a_valid && a_out_addr == 5'd7, 1);
    ready_a = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("bp_hold_valid", a_valid, 1);
      check("bp_hold_addr", a_out_addr, 7);
      check("bp_hold_data", a_out_data, 32'h0707_0707);
      step();
    end
    check("bp_still7", a_out_addr, 7);
    ready_a = 1'b1;
    run_a(150);
    check("bp_beats", beats_a, 32);
    check("bp_done_count", done_cnt_a, 1);
    check("bp_done_cyc", done_cyc_a, 70);
    check("bp_sb_empty", q_a.size(), 0);

    // Walk that skips x0.
    clr_mon();
    push_b(1, 31);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    run_b(150);
    check("skip_beats", beats_b, 31);
    check("skip_first_addr", first_addr_b, 1);
    check("skip_last_addr", last_addr_b, 31);
    check("skip_first_valid_cyc", first_cyc_b, 2);
    check("skip_done_cyc", done_cyc_b, 63);
    check("skip_done_count", done_cnt_b, 1);
    check("skip_sb_empty", q_b.size(), 0);
    check("skip_a_untouched", beats_a, 0);

    // Abort coinciding with the handshake of index 12.
    clr_mon();
    push_a(0, 12, 32'h0909_0909);
    kick_a();
    for (int k = 0; k < 100 && !(a_valid && a_out_addr == 5'd12); k++) step();
    check("abort_reach12", a_valid && a_out_addr == 5'd12, 1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("abort_valid", a_valid, 0);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_rf_addr_hold", a_rf_addr, 12);
    repeat (8) step();
    check("abort_beats", beats_a, 13);
    check("abort_no_done", done_cnt_a, 0);
    check("abort_sb_empty", q_a.size(), 0);

    // Restart after abort begins again at index 0.
    clr_mon();
    push_a(0, 31, 32'h0909_0909);
    kick_a();
    run_a(150);
    check("restart_beats", beats_a, 32);
    check("restart_done_cyc", done_cyc_a, 65);
    check("restart_sb_empty", q_a.size(), 0);

    // Start while busy is ignored; write to x9 during its READ returns old value.
    clr_mon();
    push_a(0, 31, 32'h0909_0909);
    kick_a();
    for (int k = 0; k < 100 && !(a_valid && a_out_addr == 5'd3); k++) step();
    check("busy_reach3", a_valid && a_out_addr == 5'd3, 1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 100 && !(a_busy && !a_valid && a_rf_addr == 5'd9); k++) step();
    check("coh_reach_read9", a_busy && !a_valid && a_rf_addr == 5'd9, 1);
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h1234_5678;
    start_a = 1'b1;
    step();
    wr_en   = 1'b0;
    start_a = 1'b0;
    run_a(150);
    check("coh_beats", beats_a, 32);
    check("coh_done_count", done_cnt_a, 1);
    check("coh_done_cyc", done_cyc_a, 65);
    check("coh_sb_empty", q_a.size(), 0);

    clr_mon();
    push_a(0, 31, 32'h1234_5678);
    kick_a();
    run_a(150);
    check("coh2_beats", beats_a, 32);
    check("coh2_sb_empty", q_a.size(), 0);

    // Asynchronous reset while index 5 is waiting in SEND.
    preload = 1'b1;
    step();
    preload = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEAD_BEEF;
    step();
    wr_en   = 1'b0;
    clr_mon();
    push_a(0, 4, 32'h0909_0909);
    kick_a();
    for (int k = 0; k < 100 && !(a_valid && a_out_addr == 5'd5); k++) step();
    check("rst_reach5", a_valid && a_out_addr == 5'd5, 1);
    ready_a = 1'b0;
    check("rst_x5_data", a_out_data, 32'hDEAD_BEEF);
    #3;
    rst = 1'b1;
    #1;
    check("rstmid_valid", a_valid, 0);
    check("rstmid_busy", a_busy, 0);
    check("rstmid_done", a_done, 0);
    check("rstmid_out_addr", a_out_addr, 0);
    check("rstmid_out_data", a_out_data, 0);
    check("rstmid_rf_addr", a_rf_addr, 0);
    repeat (3) step();
    rst = 1'b0;
    ready_a = 1'b1;
    repeat (3) step();
    check("rstmid_no_done", done_cnt_a, 0);
    check("rstmid_beats", beats_a, 5);
    check("rstmid_sb_empty", q_a.size(), 0);
    check("rstmid_idle_busy", a_busy, 0);
    check("rstmid_idle_valid", a_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
